// File: rtl/glb_stream_pkg.sv
`default_nettype none
// ============================================================================
// glb_stream_pkg : shared widths, parser states and FIFO entry type for the
//                  GLB stream deframer.
// Rev 1.0
// ============================================================================
package glb_stream_pkg;

    localparam int GLB_DATA_W    = 17;
    localparam int GLB_PAYLOAD_W = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        LEN   = 3'd2,
        PAY   = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } deframe_state_t;

    typedef struct packed {
        logic [GLB_PAYLOAD_W-1:0] data;
        logic                     seg;
        logic                     last;
    } payload_t;

endpackage
`default_nettype wire

// File: rtl/glb_stream_skid_fifo.sv
`default_nettype none
// ============================================================================
// glb_stream_skid_fifo : 2-entry payload FIFO {data,seg,last}, cleared by flush.
// Rev 1.0
// ============================================================================
module glb_stream_skid_fifo
    import glb_stream_pkg::*;
(
    input  logic     clk,
    input  logic     flush,
    input  logic     i_push,
    input  payload_t i_push_data,
    input  logic     i_pop,
    output payload_t o_head,
    output logic     o_full,
    output logic     o_empty
);

    payload_t   r_mem [0:1];
    logic       r_wptr;
    logic       r_rptr;
    logic [1:0] r_count;
    logic       w_push_ok;
    logic       w_pop_ok;

    assign o_full    = (r_count == 2'd2);
    assign o_empty   = (r_count == 2'd0);
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;
    // Head reads as zero when empty so the output port is clean between bursts.
    assign o_head    = o_empty ? '0 : r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (flush) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wptr] <= i_push_data;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop_ok) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/glb_stream_deframer.sv
`default_nettype none
// ============================================================================
// glb_stream_deframer : strips header/length framing from the GLB->tile stream
//                       and emits payload tagged with stream index and last.
// Optional: GLB_STREAM_DEFRAME_PERF_EN adds saturating stall counters.
// Rev 1.0
// ============================================================================
module glb_stream_deframer
    import glb_stream_pkg::*;
#(
    parameter int DATA_W = GLB_DATA_W,
    parameter int LEN_W  = 16,
    parameter int TXN_W  = 16
) (
    input  logic                     clk,
    input  logic                     flush,
    input  logic                     cfg_en,
    input  logic                     cfg_seg_mode,
    input  logic [TXN_W-1:0]         cfg_tx_num,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [GLB_PAYLOAD_W-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_seg,
    output logic                     out_last,
    output logic [GLB_PAYLOAD_W-1:0] hdr_q,
    output logic                     done
`ifdef GLB_STREAM_DEFRAME_PERF_EN
   ,output logic [31:0]              perf_in_stall,
    output logic [31:0]              perf_out_stall
`endif
);

    localparam logic [2:0] S_IDLE  = 3'(IDLE);
    localparam logic [2:0] S_HDR   = 3'(HDR);
    localparam logic [2:0] S_LEN   = 3'(LEN);
    localparam logic [2:0] S_PAY   = 3'(PAY);
    localparam logic [2:0] S_DRAIN = 3'(DRAIN);
    localparam logic [2:0] S_DONE  = 3'(DONE);

    logic [2:0]               r_state;
    logic                     r_seg_mode;
    logic                     r_strm;
    logic [TXN_W-1:0]         r_tx_num;
    logic [TXN_W-1:0]         r_txn_cnt;
    logic [LEN_W-1:0]         r_rem;
    logic [GLB_PAYLOAD_W-1:0] r_hdr;

    logic                     w_in_ready;
    logic                     w_accept;
    logic                     w_strm_end;
    logic [TXN_W-1:0]         w_txn_next;
    logic [LEN_W-1:0]         w_len;
    logic                     w_full;
    logic                     w_empty;
    logic                     w_push;
    payload_t                 w_push_data;
    payload_t                 w_head;
    logic                     w_unused_rsvd;

    // Reserved bit is ignored rather than checked; it never reaches the output.
    assign w_unused_rsvd = ^in_data[DATA_W-1:GLB_PAYLOAD_W];

    assign w_in_ready = (r_state == S_HDR) | (r_state == S_LEN) |
                        ((r_state == S_PAY) & ~w_full);
    assign w_accept   = in_valid & w_in_ready;
    assign w_len      = in_data[LEN_W-1:0];
    assign w_txn_next = r_txn_cnt + {{(TXN_W-1){1'b0}}, 1'b1};
    assign w_strm_end = w_accept &
                        (((r_state == S_LEN) & (w_len == '0)) |
                         ((r_state == S_PAY) & (r_rem == {{(LEN_W-1){1'b0}}, 1'b1})));

    assign w_push           = w_accept & (r_state == S_PAY);
    assign w_push_data.data = in_data[GLB_PAYLOAD_W-1:0];
    assign w_push_data.seg  = r_strm;
    assign w_push_data.last = (r_rem == {{(LEN_W-1){1'b0}}, 1'b1});

    always_ff @(posedge clk) begin
        if (flush) begin
            r_state    <= S_IDLE;
            r_seg_mode <= 1'b0;
            r_strm     <= 1'b0;
            r_tx_num   <= '0;
            r_txn_cnt  <= '0;
            r_rem      <= '0;
            r_hdr      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cfg_en) begin
                        r_tx_num  <= cfg_tx_num;
                        r_txn_cnt <= '0;
                        r_state   <= (cfg_tx_num == '0) ? S_DONE : S_HDR;
                    end
                end
                S_HDR: begin
                    if (w_accept) begin
                        r_hdr      <= in_data[GLB_PAYLOAD_W-1:0];
                        r_seg_mode <= cfg_seg_mode;
                        r_strm     <= 1'b0;
                        r_state    <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (w_accept && (w_len != '0)) begin
                        r_rem   <= w_len;
                        r_state <= S_PAY;
                    end
                end
                S_PAY: begin
                    if (w_accept) begin
                        r_rem <= r_rem - {{(LEN_W-1){1'b0}}, 1'b1};
                    end
                end
                S_DRAIN: begin
                    if (w_empty) begin
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= r_state;
            endcase

            // Shared end-of-stream decision for both LEN (zero length) and PAY.
            if (w_strm_end) begin
                if (!r_strm && r_seg_mode) begin
                    r_strm  <= 1'b1;
                    r_state <= S_LEN;
                end else begin
                    r_txn_cnt <= w_txn_next;
                    r_state   <= (w_txn_next == r_tx_num) ? S_DRAIN : S_HDR;
                end
            end
        end
    end

    glb_stream_skid_fifo u_fifo (
        .clk         (clk),
        .flush       (flush),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (out_ready),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    assign in_ready  = w_in_ready;
    assign out_valid = ~w_empty;
    assign out_data  = w_head.data;
    assign out_seg   = w_head.seg;
    assign out_last  = w_head.last;
    assign hdr_q     = r_hdr;
    assign done      = (r_state == S_DONE);

`ifdef GLB_STREAM_DEFRAME_PERF_EN
    logic [31:0] r_perf_in_stall;
    logic [31:0] r_perf_out_stall;
    logic        w_parsing;

    assign w_parsing = (r_state == S_HDR) | (r_state == S_LEN) | (r_state == S_PAY);

    always_ff @(posedge clk) begin
        if (flush) begin
            r_perf_in_stall  <= '0;
            r_perf_out_stall <= '0;
        end else begin
            if (w_parsing && in_valid && !w_in_ready && (r_perf_in_stall != '1)) begin
                r_perf_in_stall <= r_perf_in_stall + 32'd1;
            end
            if (!w_empty && !out_ready && (r_perf_out_stall != '1)) begin
                r_perf_out_stall <= r_perf_out_stall + 32'd1;
            end
        end
    end

    assign perf_in_stall  = r_perf_in_stall;
    assign perf_out_stall = r_perf_out_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_glb_stream_deframer.sv
`default_nettype none
// ============================================================================
// tb_glb_stream_deframer : scoreboard bench; a frame-walking reference model
//                          predicts payload words, a monitor pops and compares.
// Rev 1.0
// ============================================================================
module tb_glb_stream_deframer;

    logic        clk = 1'b0;
    logic        flush;
    logic        cfg_en;
    logic        cfg_seg_mode;
    logic [15:0] cfg_tx_num;
    logic [16:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_seg;
    logic        out_last;
    logic [15:0] hdr_q;
    logic        done;
`ifdef GLB_STREAM_DEFRAME_PERF_EN
    logic [31:0] perf_in_stall;
    logic [31:0] perf_out_stall;
`endif

    always #5 clk = ~clk;

    glb_stream_deframer dut (
        .clk          (clk),
        .flush        (flush),
        .cfg_en       (cfg_en),
        .cfg_seg_mode (cfg_seg_mode),
        .cfg_tx_num   (cfg_tx_num),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_seg      (out_seg),
        .out_last     (out_last),
        .hdr_q        (hdr_q),
        .done         (done)
`ifdef GLB_STREAM_DEFRAME_PERF_EN
       ,.perf_in_stall  (perf_in_stall),
        .perf_out_stall (perf_out_stall)
`endif
    );

    int          vectors     = 0;
    int          miscompares = 0;
    logic [17:0] exp_q[$];
    logic [16:0] words[$];
    logic [15:0] exp_hdr;
    int          rdy_mode = 1;   // 0 random, 1 always ready, 2 stalled
    int          gap_max  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference: walk the framed word list exactly as the format defines it.
    task automatic model(input bit seg_mode, input int txn);
        int idx = 0;
        for (int t = 0; t < txn; t++) begin
            exp_hdr = words[idx][15:0];
            idx++;
            for (int s = 0; s < (seg_mode ? 2 : 1); s++) begin
                int len = int'(words[idx][15:0]);
                idx++;
                for (int k = 0; k < len; k++) begin
                    exp_q.push_back({words[idx][15:0], s[0], (k == len - 1)});
                    idx++;
                end
            end
        end
    endtask

    task automatic gen_random(input bit seg_mode, input int txn);
        words.delete();
        for (int t = 0; t < txn; t++) begin
            words.push_back({1'b0, 16'($urandom)});
            for (int s = 0; s < (seg_mode ? 2 : 1); s++) begin
                int len = $urandom_range(0, 4);
                words.push_back({1'b0, 16'(len)});
                for (int k = 0; k < len; k++) words.push_back(17'($urandom));
            end
        end
    endtask

    task automatic do_reset();
        exp_q.delete();
        flush    = 1'b1;
        cfg_en   = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        exp_hdr  = '0;
        repeat (2) @(posedge clk);
        #1 flush = 1'b0;
    endtask

    task automatic start(input bit seg_mode, input int txn);
        cfg_seg_mode = seg_mode;
        cfg_tx_num   = 16'(txn);
        cfg_en       = 1'b1;
        @(posedge clk);
        #1 cfg_en = 1'b0;
    endtask

    task automatic send(input logic [16:0] w);
        int n = 0;
        if (gap_max > 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, gap_max)) begin
                @(posedge clk);
                #1;
            end
        end
        in_data  = w;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 2000) begin
                vectors++;
                miscompares++;
                $display("FAIL send_timeout: in_ready stuck low, word 0x%0h", w);
                break;
            end
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done"}, 32'(done), 32'd1);
        check({name, "_drained"}, exp_q.size(), 0);
        check({name, "_hdr_q"}, 32'(hdr_q), 32'(exp_hdr));
        @(posedge clk);
        #1;
    endtask

    task automatic run(input string name, input bit seg_mode, input int txn);
        model(seg_mode, txn);
        start(seg_mode, txn);
        foreach (words[i]) send(words[i]);
        wait_done(name);
    endtask

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = ($urandom_range(0, 3) != 0);
                1:       out_ready = 1'b1;
                default: out_ready = 1'b0;
            endcase
        end
    end

    initial begin
        logic [17:0] e;
        forever begin
            @(negedge clk);
            if (!flush && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL out_unexpected: got data 0x%0h seg %0d last %0d, expected nothing",
                             out_data, out_seg, out_last);
                end else begin
                    e = exp_q.pop_front();
                    check("out_word", {14'd0, out_data, out_seg, out_last}, {14'd0, e});
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        do_reset();
        check("rst_in_ready",  32'(in_ready),  0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_seg",   32'(out_seg),   0);
        check("rst_out_last",  32'(out_last),  0);
        check("rst_out_data",  32'(out_data),  0);
        check("rst_hdr_q",     32'(hdr_q),     0);
        check("rst_done",      32'(done),      0);

        // Single stream, three payload words
        rdy_mode = 1;
        words = '{17'h00005, 17'd3, 17'h0000A, 17'h0000B, 17'h0000C};
        run("t1", 1'b0, 1);

        // Two streams per transaction
        do_reset();
        words = '{17'h00009, 17'd2, 17'd1, 17'd2, 17'd1, 17'd7};
        run("t2", 1'b1, 1);

        // Zero-length first stream emits nothing
        do_reset();
        words = '{17'h00002, 17'd0, 17'd2, 17'd5, 17'd6};
        run("t3", 1'b1, 1);

        // Downstream stall: FIFO fills after two words, then backpressures
        do_reset();
        rdy_mode = 2;
        words = '{17'h00003, 17'd5, 17'h00111, 17'h00222, 17'h00333, 17'h00444, 17'h00555};
        model(1'b0, 1);
        start(1'b0, 1);
        for (int i = 0; i < 4; i++) send(words[i]);
        in_data  = words[4];
        in_valid = 1'b1;
        repeat (10) @(negedge clk);
        check("t4_in_ready_full", 32'(in_ready), 0);
        check("t4_out_valid_held", 32'(out_valid), 1);
        check("t4_out_data_held", 32'(out_data), 32'h111);
        @(posedge clk);
        #1 rdy_mode = 1;
        for (int i = 4; i < 7; i++) send(words[i]);
        wait_done("t4");

        // Flush mid-transfer, then a clean rerun
        do_reset();
        rdy_mode = 2;
        words = '{17'h00005, 17'd3, 17'h0000A, 17'h0000B, 17'h0000C};
        start(1'b0, 1);
        for (int i = 0; i < 4; i++) send(words[i]);
        exp_q.delete();
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("t5_out_valid", 32'(out_valid), 0);
        check("t5_done",      32'(done),      0);
        check("t5_in_ready",  32'(in_ready),  0);
        check("t5_hdr_q",     32'(hdr_q),     0);
        @(posedge clk);
        #1 rdy_mode = 1;
        run("t5_rerun", 1'b0, 1);

        // tx_num = 0: done without consuming input
        do_reset();
        words.delete();
        start(1'b0, 0);
        in_data  = 17'h01234;
        in_valid = 1'b1;
        @(negedge clk);
        check("t6_zero_in_ready", 32'(in_ready), 0);
        check("t6_zero_done",     32'(done),     1);
        @(posedge clk);
        #1 in_valid = 1'b0;

        // Back-to-back transactions with random gaps on both sides
        rdy_mode = 0;
        gap_max  = 2;
        do_reset();
        gen_random(1'b1, 2);
        run("t6_two_txn", 1'b1, 2);
        for (int it = 0; it < 20; it++) begin
            bit sm;
            int tn;
            sm = 1'($urandom_range(0, 1));
            tn = $urandom_range(1, 3);
            do_reset();
            gen_random(sm, tn);
            run("rand", sm, tn);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
